conv_output_scheduler: RTL

Sits between the conv kernel array and the single-port feature-map RAM. It captures each finished kernel row result, tagged by the controller's feature_idx and feature_row, into a small FIFO. It arbitrates the one RAM port between these result writes and read requests from the downstream pooling layer, and pulses map_done once all rows of a feature map are stored.

---
 rtl/conv_output_scheduler_pkg.sv | 22 ++
 rtl/conv_result_fifo.sv | 60 ++++++
 rtl/conv_output_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/conv_output_scheduler_pkg.sv
// Shared types and helpers for the conv output scheduler: arbiter encodings,
// feature-map geometry defaults and the RAM address packing rule.
package conv_output_scheduler_pkg;

    localparam int TOTAL_WEIGHT_DEF = 4;
    localparam int TOTAL_SHIFT_DEF  = 4;
    localparam int IDX_W            = 2;
    localparam int ROW_W            = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_WR   = 2'b01,
        ARB_RD   = 2'b10
    } arb_state_e;

    // A map occupies TOTAL_SHIFT consecutive words, so the address is idx*TOTAL_SHIFT+row.
    function automatic logic [IDX_W+ROW_W-1:0] pack_addr(input logic [IDX_W-1:0] idx,
                                                         input logic [ROW_W-1:0] row);
        return {idx, row};
    endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// Small synchronous FIFO holding tagged kernel row results; a push into a full
// FIFO succeeds when a pop happens in the same cycle.
module conv_result_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH      = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [WIDTH-1:0]                   din,
    output logic [WIDTH-1:0]                   dout,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               full,
    output logic                               empty
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});

    // Entry storage; contents only matter while counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/conv_output_scheduler.sv
// Queues finished kernel rows, shares the single RAM port between result writes
// and pooling reads, and flags each feature map once all its rows are stored.
module conv_output_scheduler
    import conv_output_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int COLS         = 4,
    parameter int TOTAL_WEIGHT = TOTAL_WEIGHT_DEF,
    parameter int TOTAL_SHIFT  = TOTAL_SHIFT_DEF,
    parameter int ADDR_WIDTH   = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_MAX   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       kernel_calc_fin,
    input  logic [1:0]                 feature_idx,
    input  logic [1:0]                 feature_row,
    input  logic [COLS*DATA_WIDTH-1:0] kernel_data,
    input  logic                       rd_req,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic [COLS*DATA_WIDTH-1:0] ram_rdata,
    output logic                       ram_we,
    output logic                       ram_re,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic [COLS*DATA_WIDTH-1:0] ram_wdata,
    output logic                       rd_gnt,
    output logic                       rd_valid,
    output logic [COLS*DATA_WIDTH-1:0] rd_data,
    output logic                       map_done,
    output logic [1:0]                 map_done_idx,
    output logic                       overflow
);
    localparam int DW_T    = COLS*DATA_WIDTH;
    localparam int ENTRY_W = IDX_W + ROW_W + DW_T;
    localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam int SW      = $clog2(STARVE_MAX+1);

    arb_state_e              state_r, state_nxt;
    logic [SW-1:0]           starve_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic                    rd_valid_r;
    logic                    map_done_r;
    logic [1:0]              map_done_idx_r;
    logic                    overflow_r;
    logic [TOTAL_SHIFT-1:0]  mask_r [TOTAL_WEIGHT];

    logic                    push_s, pop_s;
    logic [ENTRY_W-1:0]      head_s;
    logic [CNT_W-1:0]        fifo_count_s, fifo_avail_s;
    logic                    fifo_full_s, fifo_empty_s;
    logic                    avail_ne_s, avail_full_s;
    logic [IDX_W-1:0]        head_idx_s;
    logic [ROW_W-1:0]        head_row_s;
    logic [TOTAL_SHIFT-1:0]  wr_mask_s;

    assign push_s     = enable && kernel_calc_fin;
    assign pop_s      = (state_r == ARB_WR) && !fifo_empty_s;
    assign head_idx_s = head_s[ENTRY_W-1 -: IDX_W];
    assign head_row_s = head_s[ENTRY_W-IDX_W-1 -: ROW_W];

    conv_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({feature_idx, feature_row, kernel_data}),
        .dout  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // The entry being written this cycle is already spoken for, so the decision looks past it.
    assign fifo_avail_s = fifo_count_s - {{(CNT_W-1){1'b0}}, pop_s};
    assign avail_ne_s   = (fifo_avail_s != {CNT_W{1'b0}});
    assign avail_full_s = (fifo_avail_s == CNT_W'(FIFO_DEPTH));

    // Next grant: writes win unless a read is waiting and the queue can still absorb it.
    always_comb begin
        state_nxt = ARB_IDLE;
        if (avail_ne_s && (!rd_req || avail_full_s || (starve_r == SW'(STARVE_MAX)))) begin
            state_nxt = ARB_WR;
        end else if (rd_req) begin
            state_nxt = ARB_RD;
        end else begin
            state_nxt = ARB_IDLE;
        end
    end

    // Row mask of the map being written, including the row landing now.
    always_comb begin
        wr_mask_s = mask_r[head_idx_s] | ({{(TOTAL_SHIFT-1){1'b0}}, 1'b1} << head_row_s);
    end

    // Arbiter state, starvation tracking and read bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ARB_IDLE;
            starve_r   <= {SW{1'b0}};
            rd_addr_r  <= {ADDR_WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            rd_valid_r <= (state_r == ARB_RD);
            case (state_nxt)
                ARB_WR: starve_r <= {SW{1'b0}};
                ARB_RD: begin
                    rd_addr_r <= rd_addr;
                    if (!avail_ne_s)                        starve_r <= {SW{1'b0}};
                    else if (starve_r != SW'(STARVE_MAX))   starve_r <= starve_r + SW'(1);
                    else                                    starve_r <= starve_r;
                end
                default: starve_r <= starve_r;
            endcase
        end
    end

    // Completion masks, map_done pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TOTAL_WEIGHT; i++) mask_r[i] <= {TOTAL_SHIFT{1'b0}};
            map_done_r     <= 1'b0;
            map_done_idx_r <= 2'b00;
            overflow_r     <= 1'b0;
        end else begin
            map_done_r <= 1'b0;
            if (push_s && fifo_full_s && !pop_s) overflow_r <= 1'b1;
            if (pop_s) begin
                if (&wr_mask_s) begin
                    mask_r[head_idx_s] <= {TOTAL_SHIFT{1'b0}};
                    map_done_r         <= 1'b1;
                    map_done_idx_r     <= head_idx_s;
                end else begin
                    mask_r[head_idx_s] <= wr_mask_s;
                end
            end
        end
    end

    assign ram_we       = (state_r == ARB_WR);
    assign ram_re       = (state_r == ARB_RD);
    assign rd_gnt       = (state_r == ARB_RD);
    assign ram_addr     = ram_we ? pack_addr(head_idx_s, head_row_s)
                                 : (ram_re ? rd_addr_r : {ADDR_WIDTH{1'b0}});
    assign ram_wdata    = ram_we ? head_s[DW_T-1:0] : {DW_T{1'b0}};
    assign rd_valid     = rd_valid_r;
    assign rd_data      = ram_rdata;
    assign map_done     = map_done_r;
    assign map_done_idx = map_done_idx_r;
    assign overflow     = overflow_r;

endmodule
